apb_arb_master: RTL and testbench
=================================

APB_ARB_MASTER -- requirements
Module: apb_arb_master

Interface
REQ-001 Parameter TIMEOUT, default 16, max ACCESS-phase cycles without cpu_pready before forced error; 0 disables timeout.
REQ-002 cpu_pclk  input  1  APB clock; all state updates on rising edge.
REQ-003 cpu_presetn  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  2  bit i: requester i has a pending transfer.
REQ-005 req_write  input  2  bit i: 1 = write, 0 = read for requester i.
REQ-006 req_addr  input  16  requester i address at [8i+7:8i].
REQ-007 req_wdata  input  16  requester i write data at [8i+7:8i].
REQ-008 req_grant  output  2  one-cycle pulse: requester i's command latched; inputs may change next cycle.
REQ-009 req_done  output  2  one-cycle pulse: requester i's transfer finished; rsp_* valid same cycle.
REQ-010 rsp_rdata  output  8  read data for completed transfer; 0 for writes and errors.
REQ-011 rsp_err  output  1  cpu_pslverr or timeout of completed transfer.
REQ-012 cpu_psel, cpu_penable, cpu_pwrite  output  1 each  APB control, registered.
REQ-013 cpu_paddr, cpu_pwdata  output  8 each  APB address/write data, registered.
REQ-014 cpu_prdata  input  8; cpu_pready  input  1; cpu_pslverr  input  1  APB slave response.

Function
REQ-015 FSM states IDLE, SETUP, ACCESS; exactly one state at a time.
REQ-016 IDLE, any req_valid set: arbiter selects winner, latches its write/addr/wdata into cpu_pwrite/cpu_paddr/cpu_pwdata, sets cpu_psel=1, cpu_penable=0, pulses req_grant[winner], enters SETUP.
REQ-017 Arbitration round-robin: both valid -> grant requester not granted last; single valid -> grant it; pointer favours requester 0 after reset.
REQ-018 SETUP -> ACCESS unconditionally after one cycle; cpu_penable=1; address/data/write held stable.
REQ-019 ACCESS, cpu_pready=1: pulse req_done[owner]; rsp_rdata = cpu_prdata for error-free read, else 0; rsp_err = cpu_pslverr; next cycle psel=penable=pwrite=0, pwdata=0, paddr held; enter IDLE.
REQ-020 ACCESS, cpu_pready=0: hold all APB outputs; wait counter increments per cycle.
REQ-021 TIMEOUT>0 and wait counter reaches TIMEOUT with cpu_pready still 0: complete as REQ-019 with rsp_err=1, rsp_rdata=0.
REQ-022 At least one IDLE cycle between transfers; minimum transfer 3 cycles grant-to-IDLE.
REQ-023 req_valid dropped before grant: request not served, no done.
REQ-024 req_valid changes during SETUP/ACCESS: ignored until IDLE.
REQ-025 Wait counter width $clog2(TIMEOUT+1); cleared on entering SETUP; saturates, no wrap.
REQ-026 rsp_rdata/rsp_err hold last value between done pulses.

Reset
REQ-027 cpu_presetn low: all outputs 0, state IDLE, counter 0, RR pointer favours requester 0, immediately and asynchronously.
REQ-028 Reset mid-transfer: transfer abandoned, no req_done pulse; new arbitration starts on first edge after deassertion.

Structure
REQ-029 Package apb_arb_pkg holds state enum (IDLE, SETUP, ACCESS), ADDR_W=8, DATA_W=8, NUM_REQ=2.
REQ-030 Sub-module rr_arbiter2: 2-way round-robin grant with last-grant pointer, updated only on grant.

Verification
REQ-031 Req0 write addr 8'h10 data 8'hA5, pready=1 in first ACCESS -> grant[0] in IDLE, psel 1 cycle before penable, done[0] 2 cycles after grant, rsp_err=0, pwdata=0 afterwards.
REQ-032 Req1 read addr 8'h20, slave drives prdata 8'h3C with pready after 3 wait cycles -> APB outputs stable while waiting, done[1] with rsp_rdata=8'h3C.
REQ-033 Both requesters valid continuously -> grants alternate 0,1,0,1; IDLE cycle between each transfer.
REQ-034 Read with pready=1, pslverr=1 -> rsp_err=1, rsp_rdata=0.
REQ-035 pready held 0, TIMEOUT=16 -> done after 16 ACCESS cycles, rsp_err=1; bus returns IDLE.
REQ-036 cpu_presetn asserted during ACCESS -> all outputs 0 same time step, no done; next request after reset granted to requester 0 when both valid.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared state encoding and bus geometry for the APB arbitrating master
package apb_arb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int NUM_REQ = 2;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; pointer moves only when a grant is taken
module rr_arbiter2 (
  input  logic       cpu_pclk,
  input  logic       cpu_presetn,
  input  logic [1:0] valid,
  input  logic       take,
  output logic [1:0] gnt
);
  logic last;
  always_comb gnt = (valid == 2'b11) ? (last ? 2'b01 : 2'b10) : valid;
  // last resets to 1 so requester 0 wins the first contested arbitration
  always_ff @(posedge cpu_pclk or negedge cpu_presetn)
    if (!cpu_presetn) last <= 1'b1;
    else if (take && |valid) last <= gnt[1];
endmodule

// File: rtl/apb_arb_master.sv
// apb_arb_master: arbitrates two requesters onto one APB master port with optional ACCESS timeout
module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                       cpu_pclk,
  input  logic                       cpu_presetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_grant,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       cpu_psel,
  output logic                       cpu_penable,
  output logic                       cpu_pwrite,
  output logic [ADDR_W-1:0]          cpu_paddr,
  output logic [DATA_W-1:0]          cpu_pwdata,
  input  logic [DATA_W-1:0]          cpu_prdata,
  input  logic                       cpu_pready,
  input  logic                       cpu_pslverr
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state;
  logic [CW-1:0] cnt, cnt_inc;
  logic [1:0] gnt;
  logic owner, win, take, tmo;
  rr_arbiter2 u_arb (
    .cpu_pclk   (cpu_pclk),
    .cpu_presetn(cpu_presetn),
    .valid      (req_valid),
    .take       (take),
    .gnt        (gnt)
  );
  always_comb begin
    win = gnt[1];
    take = (state == IDLE) && |req_valid;
    cnt_inc = &cnt ? cnt : cnt + CW'(1);
    tmo = (TIMEOUT > 0) && (cnt_inc == CW'(TIMEOUT));
  end
  always_ff @(posedge cpu_pclk or negedge cpu_presetn)
    if (!cpu_presetn) begin
      state <= IDLE;
      cnt <= '0;
      owner <= 1'b0;
      req_grant <= '0;
      req_done <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      cpu_psel <= 1'b0;
      cpu_penable <= 1'b0;
      cpu_pwrite <= 1'b0;
      cpu_paddr <= '0;
      cpu_pwdata <= '0;
    end else begin
      req_grant <= '0;
      req_done <= '0;
      case (state)
        IDLE: if (take) begin
          state <= SETUP;
          cnt <= '0;
          owner <= win;
          req_grant <= gnt;
          cpu_psel <= 1'b1;
          cpu_penable <= 1'b0;
          cpu_pwrite <= req_write[win];
          cpu_paddr <= req_addr[ADDR_W*win +: ADDR_W];
          cpu_pwdata <= req_wdata[DATA_W*win +: DATA_W];
        end
        SETUP: begin
          state <= ACCESS;
          cpu_penable <= 1'b1;
        end
        ACCESS: if (cpu_pready || tmo) begin
          // a real pready wins over a timeout landing in the same cycle
          state <= IDLE;
          req_done <= NUM_REQ'(1) << owner;
          rsp_err <= cpu_pready ? cpu_pslverr : 1'b1;
          rsp_rdata <= (cpu_pready && !cpu_pwrite && !cpu_pslverr) ? cpu_prdata : '0;
          cpu_psel <= 1'b0;
          cpu_penable <= 1'b0;
          cpu_pwrite <= 1'b0;
          cpu_pwdata <= '0;
        end else cnt <= cnt_inc;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_arb_master.sv
// tb_apb_arb_master: directed transfers checked every cycle against a transfer-age model
module tb_apb_arb_master;
  localparam int TO = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] valid = '0, write = '0;
  logic [15:0] addr = '0, wdata = '0;
  logic [1:0] grant, done;
  logic [7:0] rdata_o, paddr, pwdata, prdata;
  logic err_o, psel, pen, pwrite, pready, pslverr;
  int errors = 0, checks = 0, cyc = 0, n_grant = 0, n_done = 0;
  int gq[$], gcyc[$], dq[$], dcyc[$];
  int wait_n = 0, acnt = 0;
  bit hang = 1'b0, slv_err = 1'b0;
  logic [7:0] slv_rdata = '0;

  apb_arb_master #(.TIMEOUT(TO)) dut (
    .cpu_pclk(clk), .cpu_presetn(rst_n),
    .req_valid(valid), .req_write(write), .req_addr(addr), .req_wdata(wdata),
    .req_grant(grant), .req_done(done), .rsp_rdata(rdata_o), .rsp_err(err_o),
    .cpu_psel(psel), .cpu_penable(pen), .cpu_pwrite(pwrite),
    .cpu_paddr(paddr), .cpu_pwdata(pwdata),
    .cpu_prdata(prdata), .cpu_pready(pready), .cpu_pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // slave: answers after wait_n unready ACCESS cycles, or never when hang is set
  assign pready = psel && pen && !hang && (acnt >= wait_n);
  assign prdata = slv_rdata;
  assign pslverr = slv_err && pready;
  always @(posedge clk) acnt <= (psel && pen && !pready) ? acnt + 1 : 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: a transfer is described by its owner and its age in cycles since grant
  bit m_busy = 1'b0, m_write = 1'b0;
  int m_age = 0, m_owner = 0, m_last = 1, w;
  logic [1:0] e_grant = '0, e_done = '0;
  logic [7:0] e_rdata = '0, e_paddr = '0, e_pwdata = '0;
  logic e_err = 1'b0, e_psel = 1'b0, e_pen = 1'b0, e_pwrite = 1'b0;

  always @(posedge clk) begin
    e_grant = '0;
    e_done = '0;
    if (!rst_n) begin
      m_busy = 1'b0; m_age = 0; m_last = 1;
      e_rdata = '0; e_err = 1'b0; e_psel = 1'b0; e_pen = 1'b0;
      e_pwrite = 1'b0; e_paddr = '0; e_pwdata = '0;
    end else if (!m_busy) begin
      if (valid != 2'b00) begin
        w = (valid == 2'b11) ? (m_last == 0 ? 1 : 0) : (valid[1] ? 1 : 0);
        m_last = w; m_owner = w; m_busy = 1'b1; m_age = 0;
        m_write = write[w];
        e_grant = 2'(1 << w);
        e_psel = 1'b1; e_pen = 1'b0; e_pwrite = write[w];
        e_paddr = addr[8*w +: 8]; e_pwdata = wdata[8*w +: 8];
      end
    end else if (m_age == 0) begin
      m_age = 1; e_pen = 1'b1;
    end else if (pready || (TO > 0 && m_age == TO)) begin
      e_done = 2'(1 << m_owner);
      e_err = pready ? pslverr : 1'b1;
      e_rdata = (pready && !m_write && !pslverr) ? prdata : 8'h00;
      e_psel = 1'b0; e_pen = 1'b0; e_pwrite = 1'b0; e_pwdata = '0;
      m_busy = 1'b0;
    end else m_age++;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    chk("outputs", {grant, done, rdata_o, err_o, psel, pen, pwrite, paddr, pwdata},
        {e_grant, e_done, e_rdata, e_err, e_psel, e_pen, e_pwrite, e_paddr, e_pwdata});
    if (grant != 2'b00) begin n_grant++; gq.push_back(int'(grant[1])); gcyc.push_back(cyc); end
    if (done != 2'b00) begin n_done++; dq.push_back(int'(done[1])); dcyc.push_back(cyc); end
  end

  task automatic wait_grant();
    int s = n_grant, b = 0;
    while (n_grant == s && b < 40) begin @(negedge clk); b++; end
    chk("grant_seen", n_grant > s, 1);
  endtask

  task automatic wait_done();
    int s = n_done, b = 0;
    while (n_done == s && b < 60) begin @(negedge clk); b++; end
    chk("done_seen", n_done > s, 1);
  endtask

  initial begin
    int s, ds, nd;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {grant, done, rdata_o, err_o, psel, pen, pwrite, paddr, pwdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // requester 0 write, immediate pready
    valid = 2'b01; write = 2'b01; addr = 16'h0010; wdata = 16'h00A5; wait_n = 0;
    wait_grant();
    valid = 2'b00;
    chk("t1_psel", psel, 1);
    chk("t1_pen_setup", pen, 0);
    chk("t1_paddr", paddr, 8'h10);
    chk("t1_pwdata", pwdata, 8'hA5);
    @(negedge clk);
    chk("t1_pen_access", pen, 1);
    wait_done();
    chk("t1_latency", dcyc[$] - gcyc[$], 2);
    chk("t1_owner", dq[$], 0);
    chk("t1_err", err_o, 0);
    chk("t1_pwdata_idle", pwdata, 0);
    chk("t1_psel_idle", psel, 0);
    // requester 1 read with three wait cycles
    valid = 2'b10; write = 2'b00; addr = 16'h2000; wait_n = 3; slv_rdata = 8'h3C;
    wait_grant();
    valid = 2'b00;
    wait_done();
    chk("t2_latency", dcyc[$] - gcyc[$], 5);
    chk("t2_owner", dq[$], 1);
    chk("t2_rdata", rdata_o, 8'h3C);
    // both requesters continuously valid
    valid = 2'b11; write = 2'b10; addr = 16'h4030; wdata = 16'h7766; wait_n = 0; slv_rdata = 8'h5A;
    s = gq.size(); ds = dcyc.size();
    repeat (4) wait_done();
    valid = 2'b00;
    for (int k = 0; k < 4; k++) chk("t3_order", gq[s + k], k % 2);
    for (int k = 0; k < 3; k++) chk("t3_idle_gap", gcyc[s + k + 1] - dcyc[ds + k], 1);
    // slave error on read
    valid = 2'b01; write = 2'b00; addr = 16'h0055; slv_rdata = 8'h77; slv_err = 1'b1;
    wait_grant();
    valid = 2'b00;
    wait_done();
    slv_err = 1'b0;
    chk("t4_err", err_o, 1);
    chk("t4_rdata", rdata_o, 0);
    // slave never ready: timeout
    hang = 1'b1;
    valid = 2'b10; write = 2'b10; addr = 16'h9900; wdata = 16'hAB00;
    wait_grant();
    valid = 2'b00;
    wait_done();
    hang = 1'b0;
    chk("t5_latency", dcyc[$] - gcyc[$], TO + 1);
    chk("t5_err", err_o, 1);
    chk("t5_rdata", rdata_o, 0);
    chk("t5_psel_idle", psel, 0);
    // reset in ACCESS after a requester 0 grant
    valid = 2'b01; write = 2'b00; addr = 16'h0011; wait_n = 8;
    wait_grant();
    valid = 2'b00;
    repeat (2) @(negedge clk);
    chk("t6_in_access", pen, 1);
    nd = n_done;
    #2 rst_n = 1'b0;
    #1 chk("t6_async_zero", {grant, done, rdata_o, err_o, psel, pen, pwrite, paddr, pwdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 2'b11; wait_n = 0;
    wait_grant();
    valid = 2'b00;
    chk("t6_no_done", n_done, nd);
    chk("t6_first_winner", gq[$], 0);
    wait_done();
    chk("t6_done_owner", dq[$], 0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
